// File: rtl/rv_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rv_pkg                                                                   |
// | Shared fetch-stage types: PC source encodings, PC FSM states, XLEN.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package rv_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        PC_SRC_BOOT = 2'b00,
        PC_SRC_EPC  = 2'b01,
        PC_SRC_TRAP = 2'b10,
        PC_SRC_SEQ  = 2'b11
    } pc_src_e;

    typedef enum logic [1:0] {
        BOOT = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10
    } pc_state_e;

endpackage
`default_nettype wire

// File: rtl/pc_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pc_unit_if                                                               |
// | Control/fetch bundle of the PC unit. PC_COMPRESSED_EN adds the 16-bit    |
// | instruction-length input.                                                |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface pc_unit_if import rv_pkg::*; #(
    parameter int XLEN = XLEN_DEFAULT
) ();

    logic             ahb_ready_in;
    logic             stall_in;
    pc_src_e          pc_src_in;
    logic             branch_taken_in;
    logic [XLEN-2:0]  iaddr_in;
    logic [XLEN-1:0]  epc_in;
    logic [XLEN-1:0]  trap_address_in;
`ifdef PC_COMPRESSED_EN
    logic             instr_len16_in;
`endif
    logic [XLEN-1:0]  i_addr_out;
    logic [XLEN-1:0]  pc_plus_4_out;
    logic             misaligned_instr_logic_out;
    logic             redirect_pending_out;

    modport master (
        output ahb_ready_in, stall_in, pc_src_in, branch_taken_in,
               iaddr_in, epc_in, trap_address_in,
`ifdef PC_COMPRESSED_EN
               instr_len16_in,
`endif
        input  i_addr_out, pc_plus_4_out, misaligned_instr_logic_out,
               redirect_pending_out
    );

    modport slave (
        input  ahb_ready_in, stall_in, pc_src_in, branch_taken_in,
               iaddr_in, epc_in, trap_address_in,
`ifdef PC_COMPRESSED_EN
               instr_len16_in,
`endif
        output i_addr_out, pc_plus_4_out, misaligned_instr_logic_out,
               redirect_pending_out
    );

endinterface
`default_nettype wire

// File: rtl/pc_target_mux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pc_target_mux                                                            |
// | Next-PC source select, sequential increment and misalignment check.      |
// | PC_COMPRESSED_EN enables +2 increment and halfword alignment check.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module pc_target_mux import rv_pkg::*; #(
    parameter int               XLEN         = XLEN_DEFAULT,
    parameter logic [XLEN-1:0]  BOOT_ADDRESS = 32'h0000_0000
) (
    input  wire logic [XLEN-1:0] pc_in,
    input  wire pc_src_e         pc_src_in,
    input  wire logic            branch_taken_in,
    input  wire logic [XLEN-2:0] iaddr_in,
    input  wire logic [XLEN-1:0] epc_in,
    input  wire logic [XLEN-1:0] trap_address_in,
`ifdef PC_COMPRESSED_EN
    input  wire logic            instr_len16_in,
`endif
    output logic      [XLEN-1:0] target_out,
    output logic                 redirect_out,
    output logic                 misaligned_out
);

    logic [XLEN-1:0] w_branch_target;
    logic [XLEN-1:0] w_seq_pc;
    logic            w_branch;

    assign w_branch_target = {iaddr_in, 1'b0};
    assign w_branch        = (pc_src_in == PC_SRC_SEQ) && branch_taken_in;

`ifdef PC_COMPRESSED_EN
    assign w_seq_pc       = pc_in + (instr_len16_in ? XLEN'(2) : XLEN'(4));
    assign misaligned_out = w_branch && w_branch_target[0];
`else
    assign w_seq_pc       = pc_in + XLEN'(4);
    assign misaligned_out = w_branch && w_branch_target[1];
`endif

    assign redirect_out = (pc_src_in != PC_SRC_SEQ) || branch_taken_in;

    always_comb begin
        target_out = w_seq_pc;
        case (pc_src_in)
            PC_SRC_BOOT: target_out = BOOT_ADDRESS;
            PC_SRC_EPC:  target_out = epc_in;
            PC_SRC_TRAP: target_out = trap_address_in;
            PC_SRC_SEQ:  target_out = branch_taken_in ? w_branch_target : w_seq_pc;
            default:     target_out = w_seq_pc;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pc_unit                                                                  |
// | Registered fetch PC with redirect buffering across AHB not-ready/stall.  |
// | Optional macro: PC_COMPRESSED_EN (16-bit instruction support).           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module pc_unit import rv_pkg::*; #(
    parameter int               XLEN         = XLEN_DEFAULT,
    parameter logic [XLEN-1:0]  BOOT_ADDRESS = 32'h0000_0000
) (
    input  wire logic clk_in,
    input  wire logic rst_in,
    pc_unit_if.slave  bus
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pending_q, pending_d;
    logic            valid_q, valid_d;
    pc_state_e       state_q, state_d;

    logic [XLEN-1:0] w_target;
    logic            w_redirect;
    logic            w_misaligned;
    logic            w_take;
    logic            w_go;

    pc_target_mux #(
        .XLEN         (XLEN),
        .BOOT_ADDRESS (BOOT_ADDRESS)
    ) u_target_mux (
        .pc_in           (pc_q),
        .pc_src_in       (bus.pc_src_in),
        .branch_taken_in (bus.branch_taken_in),
        .iaddr_in        (bus.iaddr_in),
        .epc_in          (bus.epc_in),
        .trap_address_in (bus.trap_address_in),
`ifdef PC_COMPRESSED_EN
        .instr_len16_in  (bus.instr_len16_in),
`endif
        .target_out      (w_target),
        .redirect_out    (w_redirect),
        .misaligned_out  (w_misaligned)
    );

    // A misaligned branch is not a redirect: the trap logic follows up with TRAP.
    assign w_take = w_redirect && !w_misaligned;
    assign w_go   = bus.ahb_ready_in && !bus.stall_in;

    always_comb begin
        pc_d      = pc_q;
        pending_d = pending_q;
        valid_d   = valid_q;
        state_d   = state_q;
        case (state_q)
            BOOT: begin
                if (bus.ahb_ready_in) begin
                    pc_d    = BOOT_ADDRESS + XLEN'(4);
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!w_misaligned) begin
                    if (w_go) begin
                        pc_d = w_target;
                    end else if (w_redirect) begin
                        pending_d = w_target;
                        valid_d   = 1'b1;
                        state_d   = HOLD;
                    end
                end
            end
            HOLD: begin
                if (w_go) begin
                    pc_d    = w_take ? w_target : pending_q;
                    valid_d = 1'b0;
                    state_d = RUN;
                end else if (w_take) begin
                    pending_d = w_target;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pc_q      <= BOOT_ADDRESS;
            pending_q <= '0;
            valid_q   <= 1'b0;
            state_q   <= BOOT;
        end else begin
            pc_q      <= pc_d;
            pending_q <= pending_d;
            valid_q   <= valid_d;
            state_q   <= state_d;
        end
    end

    assign bus.i_addr_out                 = pc_q;
    assign bus.pc_plus_4_out              = pc_q + XLEN'(4);
    assign bus.misaligned_instr_logic_out = w_misaligned;
    assign bus.redirect_pending_out       = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pc_unit                                                               |
// | Directed self-checking bench for pc_unit (honours PC_COMPRESSED_EN).     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_pc_unit;
    import rv_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pc_unit_if #(.XLEN(32)) bus ();

    pc_unit #(
        .XLEN         (32),
        .BOOT_ADDRESS (32'h0000_0000)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (bus.i_addr_out !== 32'h0) begin errors++; $display("FAIL reset_iaddr: got %h expected %h", bus.i_addr_out, 32'h0); end
        checks++; if (bus.pc_plus_4_out !== 32'h4) begin errors++; $display("FAIL reset_plus4: got %h expected %h", bus.pc_plus_4_out, 32'h4); end
        checks++; if (bus.redirect_pending_out !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b expected 0", bus.redirect_pending_out); end
        checks++; if (bus.misaligned_instr_logic_out !== 1'b0) begin errors++; $display("FAIL reset_misaligned: got %b expected 0", bus.misaligned_instr_logic_out); end
        rst = 1'b0;
        tick();
        checks++; if (bus.i_addr_out !== 32'h0) begin errors++; $display("FAIL boot_wait: got %h expected %h", bus.i_addr_out, 32'h0); end
    endtask

    task automatic test_sequential();
        bus.ahb_ready_in = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++; if (bus.i_addr_out !== 32'(4 * i)) begin errors++; $display("FAIL seq_%0d: got %h expected %h", i, bus.i_addr_out, 32'(4 * i)); end
        end
    endtask

    task automatic test_branch();
        bus.pc_src_in = PC_SRC_EPC;
        bus.epc_in    = 32'h100;
        tick();
        checks++; if (bus.i_addr_out !== 32'h100) begin errors++; $display("FAIL epc_redirect: got %h expected %h", bus.i_addr_out, 32'h100); end
        bus.pc_src_in       = PC_SRC_SEQ;
        bus.branch_taken_in = 1'b1;
        bus.iaddr_in        = 31'h100;
        tick();
        checks++; if (bus.i_addr_out !== 32'h200) begin errors++; $display("FAIL branch: got %h expected %h", bus.i_addr_out, 32'h200); end
        checks++; if (bus.pc_plus_4_out !== 32'h204) begin errors++; $display("FAIL branch_plus4: got %h expected %h", bus.pc_plus_4_out, 32'h204); end
        bus.branch_taken_in = 1'b0;
    endtask

    task automatic test_trap_hold();
        bus.ahb_ready_in    = 1'b0;
        bus.pc_src_in       = PC_SRC_TRAP;
        bus.trap_address_in = 32'h80;
        tick();
        checks++; if (bus.redirect_pending_out !== 1'b1) begin errors++; $display("FAIL trap_pending_rise: got %b expected 1", bus.redirect_pending_out); end
        bus.pc_src_in = PC_SRC_SEQ;
        repeat (3) tick();
        checks++; if (bus.i_addr_out !== 32'h200) begin errors++; $display("FAIL trap_hold_pc: got %h expected %h", bus.i_addr_out, 32'h200); end
        checks++; if (bus.redirect_pending_out !== 1'b1) begin errors++; $display("FAIL trap_hold_pending: got %b expected 1", bus.redirect_pending_out); end
        bus.ahb_ready_in = 1'b1;
        tick();
        checks++; if (bus.i_addr_out !== 32'h80) begin errors++; $display("FAIL trap_release: got %h expected %h", bus.i_addr_out, 32'h80); end
        checks++; if (bus.redirect_pending_out !== 1'b0) begin errors++; $display("FAIL trap_pending_fall: got %b expected 0", bus.redirect_pending_out); end
    endtask

    task automatic test_last_wins();
        bus.ahb_ready_in    = 1'b0;
        bus.pc_src_in       = PC_SRC_TRAP;
        bus.trap_address_in = 32'h180;
        tick();
        bus.pc_src_in = PC_SRC_EPC;
        bus.epc_in    = 32'h44;
        tick();
        bus.pc_src_in = PC_SRC_SEQ;
        tick();
        checks++; if (bus.i_addr_out !== 32'h80) begin errors++; $display("FAIL last_wins_hold: got %h expected %h", bus.i_addr_out, 32'h80); end
        bus.ahb_ready_in = 1'b1;
        tick();
        checks++; if (bus.i_addr_out !== 32'h44) begin errors++; $display("FAIL last_wins: got %h expected %h", bus.i_addr_out, 32'h44); end
    endtask

    task automatic test_new_redirect_wins();
        bus.ahb_ready_in    = 1'b0;
        bus.pc_src_in       = PC_SRC_TRAP;
        bus.trap_address_in = 32'h180;
        tick();
        bus.ahb_ready_in = 1'b1;
        bus.pc_src_in    = PC_SRC_EPC;
        bus.epc_in       = 32'h300;
        tick();
        checks++; if (bus.i_addr_out !== 32'h300) begin errors++; $display("FAIL release_new_wins: got %h expected %h", bus.i_addr_out, 32'h300); end
        checks++; if (bus.redirect_pending_out !== 1'b0) begin errors++; $display("FAIL release_new_pending: got %b expected 0", bus.redirect_pending_out); end
        bus.pc_src_in = PC_SRC_SEQ;
    endtask

    task automatic test_stall();
        bus.stall_in = 1'b1;
        tick();
        checks++; if (bus.i_addr_out !== 32'h300) begin errors++; $display("FAIL stall_hold: got %h expected %h", bus.i_addr_out, 32'h300); end
        bus.pc_src_in       = PC_SRC_TRAP;
        bus.trap_address_in = 32'h180;
        tick();
        checks++; if (bus.i_addr_out !== 32'h300) begin errors++; $display("FAIL stall_capture_pc: got %h expected %h", bus.i_addr_out, 32'h300); end
        checks++; if (bus.redirect_pending_out !== 1'b1) begin errors++; $display("FAIL stall_capture_pending: got %b expected 1", bus.redirect_pending_out); end
        bus.pc_src_in = PC_SRC_SEQ;
        bus.stall_in  = 1'b0;
        tick();
        checks++; if (bus.i_addr_out !== 32'h180) begin errors++; $display("FAIL stall_release: got %h expected %h", bus.i_addr_out, 32'h180); end
    endtask

    task automatic test_misaligned();
        logic        exp_mis;
        logic [31:0] exp_pc;
`ifdef PC_COMPRESSED_EN
        exp_mis = 1'b0;
        exp_pc  = 32'h202;
`else
        exp_mis = 1'b1;
        exp_pc  = 32'h180;
`endif
        bus.pc_src_in       = PC_SRC_SEQ;
        bus.branch_taken_in = 1'b1;
        bus.iaddr_in        = 31'h101;
        #1;
        checks++; if (bus.misaligned_instr_logic_out !== exp_mis) begin errors++; $display("FAIL misaligned_flag: got %b expected %b", bus.misaligned_instr_logic_out, exp_mis); end
        tick();
        checks++; if (bus.i_addr_out !== exp_pc) begin errors++; $display("FAIL misaligned_pc: got %h expected %h", bus.i_addr_out, exp_pc); end
        bus.branch_taken_in = 1'b0;
        #1;
        checks++; if (bus.misaligned_instr_logic_out !== 1'b0) begin errors++; $display("FAIL misaligned_clear: got %b expected 0", bus.misaligned_instr_logic_out); end
`ifdef PC_COMPRESSED_EN
        bus.instr_len16_in = 1'b1;
        tick();
        checks++; if (bus.i_addr_out !== 32'h204) begin errors++; $display("FAIL compressed_inc: got %h expected %h", bus.i_addr_out, 32'h204); end
        checks++; if (bus.pc_plus_4_out !== 32'h208) begin errors++; $display("FAIL compressed_plus4: got %h expected %h", bus.pc_plus_4_out, 32'h208); end
        bus.instr_len16_in = 1'b0;
`endif
    endtask

    task automatic test_reset_in_hold();
        bus.ahb_ready_in    = 1'b0;
        bus.pc_src_in       = PC_SRC_TRAP;
        bus.trap_address_in = 32'h80;
        tick();
        rst           = 1'b1;
        bus.pc_src_in = PC_SRC_SEQ;
        tick();
        checks++; if (bus.i_addr_out !== 32'h0) begin errors++; $display("FAIL hold_reset_pc: got %h expected %h", bus.i_addr_out, 32'h0); end
        checks++; if (bus.redirect_pending_out !== 1'b0) begin errors++; $display("FAIL hold_reset_pending: got %b expected 0", bus.redirect_pending_out); end
        rst = 1'b0;
        tick();
        checks++; if (bus.i_addr_out !== 32'h0) begin errors++; $display("FAIL hold_reset_boot: got %h expected %h", bus.i_addr_out, 32'h0); end
    endtask

    task automatic test_wrap();
        bus.ahb_ready_in = 1'b1;
        tick();
        checks++; if (bus.i_addr_out !== 32'h4) begin errors++; $display("FAIL reboot_first: got %h expected %h", bus.i_addr_out, 32'h4); end
        bus.pc_src_in = PC_SRC_EPC;
        bus.epc_in    = 32'hFFFF_FFFC;
        tick();
        checks++; if (bus.i_addr_out !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_top: got %h expected %h", bus.i_addr_out, 32'hFFFF_FFFC); end
        checks++; if (bus.pc_plus_4_out !== 32'h0) begin errors++; $display("FAIL wrap_plus4: got %h expected %h", bus.pc_plus_4_out, 32'h0); end
        bus.pc_src_in = PC_SRC_SEQ;
        tick();
        checks++; if (bus.i_addr_out !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h expected %h", bus.i_addr_out, 32'h0); end
    endtask

    initial begin
        rst                 = 1'b1;
        bus.ahb_ready_in    = 1'b0;
        bus.stall_in        = 1'b0;
        bus.pc_src_in       = PC_SRC_SEQ;
        bus.branch_taken_in = 1'b0;
        bus.iaddr_in        = '0;
        bus.epc_in          = '0;
        bus.trap_address_in = '0;
`ifdef PC_COMPRESSED_EN
        bus.instr_len16_in  = 1'b0;
`endif
        test_reset();
        test_sequential();
        test_branch();
        test_trap_hold();
        test_last_wins();
        test_new_redirect_wins();
        test_stall();
        test_misaligned();
        test_reset_in_hold();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_unit.md
# pc_unit

Registered, parameterised program-counter unit for the RISC-V core's fetch stage, successor to the combinational PC mux. It holds the architectural fetch PC in a register and selects the next PC from boot, EPC, trap or sequential/branch sources. It buffers a redirect that arrives while the AHB instruction port is not ready, so the redirect is not lost. It drives the instruction address onto the AHB fetch interface and flags misaligned branch targets to the trap logic.

## Interface
- XLEN, 32, address/PC width
- BOOT_ADDRESS, 32'h0000_0000, PC value after reset (XLEN bits)
- clk_in  input  1  core clock; all state updates on rising edge
- rst_in  input  1  synchronous, active-high reset
- ahb_ready_in  input  1  AHB instruction port accepts i_addr_out this cycle
- stall_in  input  1  pipeline hazard stall; holds PC, does not block redirect capture
- pc_src_in  input  2  00 boot, 01 epc, 10 trap, 11 sequential/branch
- branch_taken_in  input  1  take iaddr_in when pc_src_in=11
- iaddr_in  input  XLEN-1  branch/jump target bits [XLEN-1:1]; bit 0 forced 0
- epc_in  input  XLEN  mret return address
- trap_address_in  input  XLEN  trap vector
- i_addr_out  output  XLEN  registered fetch address (= PC register)
- pc_plus_4_out  output  XLEN  PC register + 4 (link value), combinational
- misaligned_instr_logic_out  output  1  combinational; taken branch with misaligned target
- redirect_pending_out  output  1  a buffered redirect is waiting for ahb_ready_in

## Operation
- States: BOOT, RUN, HOLD. Reset enters BOOT. Reset also sets PC to BOOT_ADDRESS and clears the pending register and valid bit.
- BOOT: i_addr_out=BOOT_ADDRESS. If ahb_ready_in=1, go to RUN and PC<=BOOT_ADDRESS+4. Otherwise stay in BOOT.
- A redirect is any of: pc_src_in≠11, or pc_src_in=11 with branch_taken_in=1.
- Target selection:
  - 00 selects BOOT_ADDRESS.
  - 01 selects epc_in.
  - 10 selects trap_address_in.
  - 11 selects {iaddr_in,1'b0} if branch_taken_in=1, else PC+4.
- RUN, ahb_ready_in=1, stall_in=0: PC<=target.
- RUN, stall_in=1, no redirect: PC holds.
- RUN, ahb_ready_in=0 or stall_in=1, with a redirect: pending<=target, valid<=1, go to HOLD. PC holds.
- HOLD, ahb_ready_in=1 and stall_in=0: PC<=pending, clear valid, go to RUN. If a new redirect arrives in this same cycle, the new redirect wins: PC<=new target.
- HOLD, not ready: a new redirect overwrites pending (last redirect wins). A sequential PC+4 never overwrites pending.
- Misaligned: asserted when pc_src_in=11, branch_taken_in=1 and target[1]=1. The redirect is then suppressed: PC and pending are unchanged. The trap logic responds with pc_src_in=10.
- Arithmetic is modulo 2^XLEN; PC+4 at 0xFFFF_FFFC wraps to 0.

## Timing
- Reset values:
  - i_addr_out=BOOT_ADDRESS
  - pc_plus_4_out=BOOT_ADDRESS+4
  - redirect_pending_out=0
  - misaligned_instr_logic_out=0 (when inputs are idle)
- Latency: a target accepted at edge N appears on i_addr_out after edge N (1 cycle).
- A buffered redirect appears on i_addr_out one cycle after the first cycle in which ahb_ready_in=1 and stall_in=0.
- redirect_pending_out is registered; it rises the cycle after capture.
- rst_in mid-HOLD discards pending; reset has priority over all inputs.

## Configuration
- PC_COMPRESSED_EN defined:
  - Adds input instr_len16_in (1 bit); the sequential increment is +2 when it is 1, else +4.
  - Misaligned check uses target[0] only. Since iaddr_in forces bit 0 to 0, the flag is never set.
  - pc_plus_4_out still reports PC+4.
- PC_COMPRESSED_EN undefined: no extra port, increment is always +4, check uses target[1].

## Structure
- Shared package rv_pkg holds:
  - pc_src encodings PC_SRC_BOOT/EPC/TRAP/SEQ
  - pc_state enum BOOT/RUN/HOLD
  - XLEN default
- One sub-module, pc_target_mux: combinational source select, increment and misalignment check. pc_unit keeps the register, pending buffer and FSM.

## Test plan
- Reset, then ahb_ready_in=1, pc_src_in=11, no branch: i_addr_out sequence 0x0, 0x4, 0x8, 0xC.
- At PC=0x100, branch_taken_in=1, iaddr_in=0x200>>1: i_addr_out=0x200 next cycle.
- ahb_ready_in=0, pc_src_in=10, trap_address_in=0x80: redirect_pending_out=1 next cycle. Hold 3 cycles, then ready=1: i_addr_out=0x80 one cycle later and redirect_pending_out=0.
- In HOLD with pending 0x80, epc_in=0x44 with pc_src_in=01 while not ready: after ready, i_addr_out=0x44.
- Branch target 0x202 without PC_COMPRESSED_EN: misaligned=1 the same cycle and PC unchanged. With PC_COMPRESSED_EN: misaligned=0 and PC=0x202.
- rst_in asserted in HOLD: next cycle i_addr_out=BOOT_ADDRESS and redirect_pending_out=0. PC+4 at 0xFFFF_FFFC wraps to 0x0.
